// File: rtl/fp_mul_normalize_round.sv
// Normalize and round stage of the FP multiplier: 2-stage pipeline turning a raw
// 48-bit significand product into IEEE-754 single fields with overflow/underflow/NaN handling.
module fp_mul_normalize_round #(
    parameter int unsigned EXP_W = 10,
    parameter int unsigned BIAS  = 127
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              ce,
    input  logic              in_valid,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exponent,
    input  logic [47:0]       in_product,
    input  logic              in_zero,
    input  logic              in_inf,
    input  logic              in_nan,
    output logic              out_valid,
    output logic              out_sign,
    output logic [7:0]        out_exponent,
    output logic [23:0]       out_significand,
    output logic              out_overflow,
    output logic              out_underflow,
    output logic              out_inexact
);

    localparam int unsigned MANT_W       = 24;
    localparam int unsigned OUT_EXP_W    = 8;
    localparam int unsigned EXP_ALL_ONES = 2 * BIAS + 1;

    localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(EXP_ALL_ONES);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic [OUT_EXP_W-1:0]    EXP_INF  = OUT_EXP_W'(EXP_ALL_ONES);
    localparam logic [MANT_W-1:0]       SIG_INF  = 24'h800000;
    localparam logic [MANT_W-1:0]       SIG_QNAN = 24'hC00000;

    // Stage 1 combinational normalize: product is in [1,4), so at most a 1-bit shift
    logic [MANT_W-1:0]       norm_mant;
    logic                    norm_guard;
    logic                    norm_sticky;
    logic signed [EXP_W-1:0] norm_exp;

    always_comb begin
        norm_mant   = in_product[46:23];
        norm_guard  = in_product[22];
        norm_sticky = |in_product[21:0];
        norm_exp    = $signed(in_exponent);
        if (in_product[47]) begin
            norm_mant   = in_product[47:24];
            norm_guard  = in_product[23];
            norm_sticky = |in_product[22:0];
            norm_exp    = $signed(in_exponent + EXP_W'(1));
        end
    end

    logic                    s1_valid;
    logic                    s1_sign;
    logic signed [EXP_W-1:0] s1_exp;
    logic [MANT_W-1:0]       s1_mant;
    logic                    s1_guard;
    logic                    s1_sticky;
    logic                    s1_zero;
    logic                    s1_inf;
    logic                    s1_nan;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exp    <= '0;
            s1_mant   <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_zero   <= 1'b0;
            s1_inf    <= 1'b0;
            s1_nan    <= 1'b0;
        end else if (ce) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign   <= in_sign;
                s1_exp    <= norm_exp;
                s1_mant   <= norm_mant;
                s1_guard  <= norm_guard;
                s1_sticky <= norm_sticky;
                s1_zero   <= in_zero;
                s1_inf    <= in_inf;
                s1_nan    <= in_nan;
            end
        end
    end

    // Stage 2 combinational round-to-nearest-even; an all-ones mantissa carries into the exponent
    logic                    round_up;
    logic [MANT_W:0]         mant_sum;
    logic [MANT_W-1:0]       rnd_mant;
    logic signed [EXP_W-1:0] rnd_exp;

    always_comb begin
        round_up = s1_guard & (s1_sticky | s1_mant[0]);
        mant_sum = {1'b0, s1_mant} + (MANT_W + 1)'(round_up);
        rnd_mant = mant_sum[MANT_W-1:0];
        rnd_exp  = s1_exp;
        if (mant_sum[MANT_W]) begin
            rnd_mant = SIG_INF;
            rnd_exp  = $signed(s1_exp + EXP_W'(1));
        end
    end

    logic                 res_sign;
    logic [OUT_EXP_W-1:0] res_exp;
    logic [MANT_W-1:0]    res_sig;
    logic                 res_ovf;
    logic                 res_unf;
    logic                 res_inx;

    // Special operands take priority over the computed exponent range checks
    always_comb begin
        res_sign = s1_sign;
        res_exp  = rnd_exp[OUT_EXP_W-1:0];
        res_sig  = rnd_mant;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        res_inx  = s1_guard | s1_sticky;
        if (s1_nan || (s1_inf && s1_zero)) begin
            res_sign = 1'b0;
            res_exp  = EXP_INF;
            res_sig  = SIG_QNAN;
            res_inx  = 1'b0;
        end else if (s1_inf) begin
            res_exp = EXP_INF;
            res_sig = SIG_INF;
            res_inx = 1'b0;
        end else if (s1_zero) begin
            res_exp = '0;
            res_sig = '0;
            res_inx = 1'b0;
        end else if (rnd_exp >= EXP_MAX) begin
            res_exp = EXP_INF;
            res_sig = SIG_INF;
            res_ovf = 1'b1;
            res_inx = 1'b1;
        end else if (rnd_exp <= EXP_ZERO) begin
            res_exp = '0;
            res_sig = '0;
            res_unf = 1'b1;
            res_inx = 1'b1;
        end
    end

    // Data outputs only load on a valid result so the packing stage sees stable fields otherwise
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid       <= 1'b0;
            out_sign        <= 1'b0;
            out_exponent    <= '0;
            out_significand <= '0;
            out_overflow    <= 1'b0;
            out_underflow   <= 1'b0;
            out_inexact     <= 1'b0;
        end else if (ce) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign        <= res_sign;
                out_exponent    <= res_exp;
                out_significand <= res_sig;
                out_overflow    <= res_ovf;
                out_underflow   <= res_unf;
                out_inexact     <= res_inx;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_normalize_round.sv
// Directed-vector bench for fp_mul_normalize_round; each task checks its own scenario.
module tb_fp_mul_normalize_round;

    logic        clock;
    logic        resetn;
    logic        ce;
    logic        in_valid;
    logic        in_sign;
    logic [9:0]  in_exponent;
    logic [47:0] in_product;
    logic        in_zero;
    logic        in_inf;
    logic        in_nan;
    logic        out_valid;
    logic        out_sign;
    logic [7:0]  out_exponent;
    logic [23:0] out_significand;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int n_cmp = 0;
    int n_bad = 0;

    fp_mul_normalize_round dut (
        .clock           (clock),
        .resetn          (resetn),
        .ce              (ce),
        .in_valid        (in_valid),
        .in_sign         (in_sign),
        .in_exponent     (in_exponent),
        .in_product      (in_product),
        .in_zero         (in_zero),
        .in_inf          (in_inf),
        .in_nan          (in_nan),
        .out_valid       (out_valid),
        .out_sign        (out_sign),
        .out_exponent    (out_exponent),
        .out_significand (out_significand),
        .out_overflow    (out_overflow),
        .out_underflow   (out_underflow),
        .out_inexact     (out_inexact)
    );

    // {valid, sign, exp[7:0], sig[23:0], ovf, unf, inx}
    wire [36:0] res = {out_valid, out_sign, out_exponent, out_significand,
                       out_overflow, out_underflow, out_inexact};
    wire [31:0] packed_word = {out_sign, out_exponent, out_significand[22:0]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic v, input logic s, input logic [9:0] e,
                         input logic [47:0] p, input logic z, input logic i, input logic n);
        in_valid    = v;
        in_sign     = s;
        in_exponent = e;
        in_product  = p;
        in_zero     = z;
        in_inf      = i;
        in_nan      = n;
    endtask

    // One isolated operation: returns #1 after the edge where the result appears
    task automatic send(input logic s, input logic [9:0] e, input logic [47:0] p,
                        input logic z, input logic i, input logic n);
        drive(1'b1, s, e, p, z, i, n);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        logic [36:0] want;
        resetn = 1'b0;
        ce     = 1'b1;
        drive(1'b0, 1'b0, 10'd0, 48'd0, 1'b0, 1'b0, 1'b0);
        #1;
        want = '0;
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", res, want);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL after_release: got %h want %h", res, want);
        end
    endtask

    task automatic test_basic();
        logic [36:0] want;
        send(1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);
        want = {1'b1, 1'b0, 8'd127, 24'h800000, 3'b000};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL one_x_one: got %h want %h", res, want);
        end
        n_cmp++;
        if (packed_word !== 32'h3F80_0000) begin
            n_bad++;
            $display("FAIL one_x_one_packed: got %h want 3f800000", packed_word);
        end
        @(posedge clock); #1;
        want = {1'b0, 1'b0, 8'd127, 24'h800000, 3'b000};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL hold_when_idle: got %h want %h", res, want);
        end
        send(1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
        want = {1'b1, 1'b0, 8'd128, 24'h900000, 3'b000};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL one5_x_one5: got %h want %h", res, want);
        end
        n_cmp++;
        if (packed_word !== 32'h4010_0000) begin
            n_bad++;
            $display("FAIL one5_packed: got %h want 40100000", packed_word);
        end
    endtask

    task automatic test_rounding();
        logic [36:0] want;
        send(1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0);
        want = {1'b1, 1'b0, 8'd127, 24'h800000, 3'b001};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL tie_even_down: got %h want %h", res, want);
        end
        send(1'b1, 10'd127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0);
        want = {1'b1, 1'b1, 8'd127, 24'h800002, 3'b001};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL tie_odd_up: got %h want %h", res, want);
        end
        send(1'b0, 10'd100, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0);
        want = {1'b1, 1'b0, 8'd101, 24'h800000, 3'b001};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL round_carry: got %h want %h", res, want);
        end
        // above half, not a tie: guard=1, sticky=1
        send(1'b0, 10'd127, 48'h4000_0060_0000, 1'b0, 1'b0, 1'b0);
        want = {1'b1, 1'b0, 8'd127, 24'h800001, 3'b001};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL above_half: got %h want %h", res, want);
        end
    endtask

    task automatic test_range();
        logic [36:0] want;
        send(1'b1, 10'd254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0);
        want = {1'b1, 1'b1, 8'hFF, 24'h800000, 3'b101};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL overflow: got %h want %h", res, want);
        end
        send(1'b0, 10'd254, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);
        want = {1'b1, 1'b0, 8'd254, 24'h800000, 3'b000};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL max_normal: got %h want %h", res, want);
        end
        send(1'b0, 10'd0, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);
        want = {1'b1, 1'b0, 8'd0, 24'h000000, 3'b011};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL underflow: got %h want %h", res, want);
        end
        send(1'b0, 10'd1, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);
        want = {1'b1, 1'b0, 8'd1, 24'h800000, 3'b000};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL min_normal: got %h want %h", res, want);
        end
        send(1'b1, 10'h3FB, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0);
        want = {1'b1, 1'b1, 8'd0, 24'h000000, 3'b011};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL negative_exp: got %h want %h", res, want);
        end
    endtask

    task automatic test_specials();
        logic [36:0] want;
        send(1'b1, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b1);
        want = {1'b1, 1'b0, 8'hFF, 24'hC00000, 3'b000};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL nan: got %h want %h", res, want);
        end
        n_cmp++;
        if (packed_word !== 32'h7FC0_0000) begin
            n_bad++;
            $display("FAIL nan_packed: got %h want 7fc00000", packed_word);
        end
        send(1'b1, 10'd127, 48'h4000_0000_0000, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL inf_times_zero: got %h want %h", res, want);
        end
        send(1'b1, 10'd300, 48'h8000_0000_0000, 1'b0, 1'b1, 1'b0);
        want = {1'b1, 1'b1, 8'hFF, 24'h800000, 3'b000};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL infinity: got %h want %h", res, want);
        end
        send(1'b1, 10'h381, 48'h4000_0040_0000, 1'b1, 1'b0, 1'b0);
        want = {1'b1, 1'b1, 8'd0, 24'h000000, 3'b000};
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL zero: got %h want %h", res, want);
        end
    endtask

    task automatic test_ce_back_to_back();
        logic [36:0] want_a;
        logic [36:0] want_b;
        logic [36:0] want_c;
        want_a = {1'b1, 1'b0, 8'd127, 24'h800000, 3'b000};
        want_b = {1'b1, 1'b0, 8'd128, 24'h900000, 3'b000};
        want_c = {1'b1, 1'b1, 8'hFF, 24'h800000, 3'b101};
        drive(1'b1, 1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        n_cmp++;
        if (res !== want_a) begin
            n_bad++;
            $display("FAIL stream_a: got %h want %h", res, want_a);
        end
        drive(1'b1, 1'b1, 10'd254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0);
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            n_cmp++;
            if (res !== want_a) begin
                n_bad++;
                $display("FAIL ce_freeze_%0d: got %h want %h", k, res, want_a);
            end
        end
        ce = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (res !== want_b) begin
            n_bad++;
            $display("FAIL stream_b: got %h want %h", res, want_b);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (res !== want_c) begin
            n_bad++;
            $display("FAIL stream_c: got %h want %h", res, want_c);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_drain: got valid %b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        logic [36:0] want;
        want = '0;
        drive(1'b1, 1'b1, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (res !== want) begin
            n_bad++;
            $display("FAIL async_reset: got %h want %h", res, want);
        end
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            n_cmp++;
            if (res !== want) begin
                n_bad++;
                $display("FAIL post_reset_%0d: got %h want %h", k, res, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_range();
        test_specials();
        test_ce_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_mul_normalize_round.md
Name: fp_mul_normalize_round

Overview:
Normalization and rounding stage of the floating-point multiplier, placed directly upstream of the result-packing register. It takes the raw 48-bit significand product, biased exponent sum and sign from the multiply stage, then normalizes, rounds to nearest-even and resolves overflow, underflow and special cases. Its out_sign/out_exponent/out_significand outputs drive the packing stage directly. The datapath is a 2-stage pipeline with a valid qualifier and a clock enable.

Parameters:
EXP_W, 10, signed internal exponent width (two's complement)
BIAS, 127, IEEE-754 single exponent bias (informational; bias is removed upstream)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
ce  in  1  pipeline clock enable; 0 freezes both stages
in_valid  in  1  input operands valid this cycle
in_sign  in  1  product sign (sign_a XOR sign_b)
in_exponent  in  10  signed biased sum e_a+e_b-127, range -127..383
in_product  in  48  unsigned 24x24 significand product, hidden bits included
in_zero  in  1  an operand is zero or denormal
in_inf  in  1  an operand is infinity
in_nan  in  1  an operand is NaN
out_valid  out  1  outputs valid
out_sign  out  1  result sign
out_exponent  out  8  biased result exponent
out_significand  out  24  rounded significand, hidden bit at [23]
out_overflow  out  1  result overflowed to infinity
out_underflow  out  1  result flushed to zero
out_inexact  out  1  rounding discarded nonzero bits

Behaviour:
- Reset (async, resetn=0): all stage registers and every output go to 0. out_valid=0 on the cycle after reset is released, until a new input is accepted.
- ce=0: no register updates, outputs hold. ce=1: both stages advance. Latency is 2 enabled cycles from in_valid to out_valid. There is no backpressure.
- Stage 1 (normalize), registered:
  - if in_product[47]=1: mant=in_product[47:24], guard=[23], sticky=|[22:0], exp=in_exponent+1
  - else: mant=[46:23], guard=[22], sticky=|[21:0], exp=in_exponent
  - sign, special flags and valid are carried alongside.
- Stage 2 (round/resolve), registered:
  - round_up = guard & (sticky | mant[0]) (round to nearest, ties to even)
  - If mant=24'hFFFFFF and round_up: mant becomes 24'h800000 and exp increments by 1.
  - Exponent arithmetic is signed EXP_W bits; it cannot wrap within the input range.
- Priority of results, highest first:
  - in_nan, or in_inf & in_zero: sign 0, exp 255, sig 24'hC00000 (quiet NaN 0x7FC00000); all flags 0
  - in_inf: exp 255, sig 24'h800000; flags 0
  - in_zero: exp 0, sig 0; flags 0
  - final exp >= 255: overflow. exp 255, sig 24'h800000, out_overflow=1, out_inexact=1
  - final exp <= 0: flush to zero. exp 0, sig 0, out_underflow=1, out_inexact=1
  - otherwise: exp[7:0], rounded mant, out_inexact = guard|sticky
- out_sign = in_sign for every case except NaN.
- When out_valid=0, data outputs hold their last value. The packing stage samples them regardless.

Test Plan:
- 1.0x1.0: product 48'h4000_0000_0000, exponent 127, in_valid=1 -> after 2 cycles out_valid=1, exp 127, sig 24'h800000, flags 0; packed result 0x3F800000.
- 1.5x1.5: product 48'h9000_0000_0000, exponent 127 -> exp 128, sig 24'h900000 (2.25 = 0x40100000), inexact 0.
- Ties to even: product[46:23]=24'h800000, [22]=1, [21:0]=0 -> sig 24'h800000, inexact 1. Same stimulus with [23]=1 (mant 24'h800001) -> sig 24'h800002.
- Rounding carry-out: product 48'h7FFF_FFC0_0000, exponent 100 -> sig 24'h800000, exp 101.
- Overflow and underflow:
  - exponent 254 with product[47]=1 -> exp 255, sig 24'h800000, overflow 1.
  - exponent 0 with product[47]=0 -> exp 0, sig 0, underflow 1.
- Specials, ce and reset:
  - in_nan=1 -> 0x7FC00000 fields.
  - in_inf & in_zero -> NaN.
  - ce held low for 3 cycles mid-stream -> outputs frozen.
  - Assert resetn=0 with both stages full -> all outputs 0 immediately (asynchronous) and out_valid stays 0 after release.
